// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: owns pc/ir, fetches over a req/valid handshake, hands off to exec control.
// Optional branch ports: define FETCH_SEQ_BRANCH_EN.
module fetch_sequencer #(
  parameter int                WIDTH    = 16,
  parameter int                I_ADDR_W = 7,
  parameter int                OP_W     = 4,
  parameter logic [OP_W-1:0]   HALT_OP  = 4'hF,
  parameter int                TIMEOUT  = 15
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic                stall,
  output logic                imem_req,
  output logic [I_ADDR_W-1:0] imem_addr,
  input  logic [WIDTH-1:0]    imem_data,
  input  logic                imem_valid,
  input  logic                exec_done,
`ifdef FETCH_SEQ_BRANCH_EN
  input  logic                br_take,
  input  logic [I_ADDR_W-1:0] br_target,
`endif
  output logic [WIDTH-1:0]    ir,
  output logic [I_ADDR_W-1:0] pc,
  output logic                inst_valid,
  output logic                halted,
  output logic                fault,
  output logic [2:0]          state
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_EXEC  = 3'd3;
  localparam logic [2:0] S_HALT  = 3'd4;

  logic [2:0]          st;
  logic [I_ADDR_W-1:0] pc_q;
  logic [WIDTH-1:0]    ir_q;
  logic                fault_q;
  logic [7:0]          to_cnt;
  logic                is_halt_op;

  assign is_halt_op = (ir_q[WIDTH-1 -: OP_W] == HALT_OP);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st      <= S_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      fault_q <= 1'b0;
      to_cnt  <= '0;
    end else begin
      case (st)
        S_IDLE: begin
          if (start) st <= S_FETCH;
        end
        S_FETCH: begin
          if (!stall) begin
            to_cnt <= '0;
            st     <= S_WAIT;
          end
        end
        S_WAIT: begin
          // stall is deliberately ignored: an issued fetch must resolve
          if (imem_valid) begin
            ir_q <= imem_data;
            pc_q <= pc_q + I_ADDR_W'(1);
            if (&pc_q) fault_q <= 1'b1;
            st   <= S_EXEC;
          end else begin
            to_cnt <= to_cnt + 8'd1;
            if (to_cnt == 8'(TIMEOUT - 1)) begin
              fault_q <= 1'b1;
              st      <= S_HALT;
            end
          end
        end
        S_EXEC: begin
          if (exec_done && !stall) begin
            if (is_halt_op) begin
              st <= S_HALT;
            end else begin
`ifdef FETCH_SEQ_BRANCH_EN
              if (br_take) pc_q <= br_target;
`endif
              st <= S_FETCH;
            end
          end
        end
        S_HALT: begin
          if (start) begin
            pc_q    <= '0;
            fault_q <= 1'b0;
            st      <= S_FETCH;
          end
        end
        default: st <= S_IDLE;
      endcase
    end
  end

  assign imem_req   = (st == S_FETCH) && !stall;
  assign imem_addr  = pc_q;
  assign pc         = pc_q;
  assign ir         = ir_q;
  assign inst_valid = (st == S_EXEC);
  assign halted     = (st == S_HALT);
  assign fault      = fault_q;
  assign state      = st;

endmodule
